// File: rtl/round_arb.sv
// Two-requester round-robin arbiter feeding a 2-stage round-to-nearest-even
// stage for single-precision results, with carry renormalization and overflow.
module round_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic             req0_sign,
  input  logic [7:0]       req0_exp,
  input  logic [27:0]      req0_mantis,
  input  logic [1:0]       req0_loss,
  input  logic             req0_op,
  input  logic             req1_sign,
  input  logic [7:0]       req1_exp,
  input  logic [27:0]      req1_mantis,
  input  logic [1:0]       req1_loss,
  input  logic             req1_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_tag,
  output logic             out_ovf,
  output logic [CNT_W-1:0] rnd_cnt,
  output logic             busy
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [1:0]  loss;
    logic        op;
  } req_t;

  req_t [1:0]       req_pl;
  logic [1:0]       grant;
  logic             win;
  logic             xfer;
  logic             s1_free;
  logic             s1_adv;

  logic             prio_q, prio_d;
  logic             s1_v_q, s1_v_d;
  logic             s1_tag_q;
  req_t             s1_q;
  logic             out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign req_pl[0] = {req0_sign, req0_exp, req0_mantis, req0_loss, req0_op};
  assign req_pl[1] = {req1_sign, req1_exp, req1_mantis, req1_loss, req1_op};

  // Arbitration: lone requester wins, a tie goes to prio.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign win       = grant[1];
  assign s1_adv    = s1_v_q & (~out_valid | out_ready);
  assign s1_free   = ~s1_v_q | s1_adv;
  assign req_ready = grant & {2{s1_free & rst_n}};
  assign xfer      = |(req_valid & req_ready);

  assign prio_d      = xfer ? ~win : prio_q;
  assign s1_v_d      = xfer | (s1_v_q & ~s1_adv);
  assign out_valid_d = s1_adv | (out_valid & ~out_ready);

  // Rounding of the S1 payload, consumed as it moves into S2.
  logic        rnd_s, up_raw, up, special;
  logic [3:0]  rnd_r;
  logic [24:0] sum;
  logic [7:0]  res_exp;
  logic [22:0] res_frac;
  logic        res_ovf;

  assign rnd_s   = (s1_q.loss[1] & (s1_q.loss[0] | ~s1_q.op)) | (~s1_q.loss[1] & s1_q.mant[4]);
  assign rnd_r   = s1_q.mant[3:0];
  assign up_raw  = (rnd_r > 4'b1000) | ((rnd_r == 4'b1000) & rnd_s);
  assign special = (s1_q.exp == 8'hFF);
  assign up      = up_raw & ~special;
  assign sum     = {1'b0, s1_q.mant[27:4]} + {24'd0, up};

  always_comb begin
    res_exp  = s1_q.exp;
    res_frac = sum[22:0];
    res_ovf  = 1'b0;
    if (special) begin
      res_frac = s1_q.mant[26:4];
    end else if (s1_q.exp == 8'h00) begin
      res_exp  = sum[24] ? 8'h01 : 8'h00;
      res_frac = sum[23:1];
    end else if (sum[24]) begin
      if (s1_q.exp == 8'hFE) begin
        res_exp  = 8'hFF;
        res_frac = '0;
        res_ovf  = 1'b1;
      end else begin
        res_exp  = s1_q.exp + 8'h01;
        res_frac = sum[23:1];
      end
    end
  end

  assign cnt_d = (s1_adv & up & ~(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_tag_q  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= 1'b0;
      out_ovf   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      prio_q    <= prio_d;
      s1_v_q    <= s1_v_d;
      out_valid <= out_valid_d;
      cnt_q     <= cnt_d;
      if (xfer) begin
        s1_q     <= req_pl[win];
        s1_tag_q <= win;
      end
      if (s1_adv) begin
        out_data <= {s1_q.sign, res_exp, res_frac};
        out_tag  <= s1_tag_q;
        out_ovf  <= res_ovf;
      end
    end
  end

  assign rnd_cnt = cnt_q;
  assign busy    = s1_v_q | out_valid;

endmodule

// File: tb/tb_round_arb.sv
// Scoreboard bench for round_arb: drivers push hand-computed results on
// transfer, a negedge monitor pops and compares each delivered result.
module tb_round_arb;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic          s0, s1, op0, op1;
  logic [7:0]    e0, e1;
  logic [27:0]   m0, m1;
  logic [1:0]    l0, l1;
  logic          out_valid, out_ready, out_tag, out_ovf, busy;
  logic [31:0]   out_data;
  logic [CW-1:0] rnd_cnt;

  assign req_valid = {v1, v0};

  round_arb #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_sign(s0), .req0_exp(e0), .req0_mantis(m0), .req0_loss(l0), .req0_op(op0),
    .req1_sign(s1), .req1_exp(e1), .req1_mantis(m1), .req1_loss(l1), .req1_op(op1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_ovf(out_ovf), .rnd_cnt(rnd_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic [1:0]  loss;
    logic        op;
    logic [31:0] dat;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        tag;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  logic tag_log[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   stall_seen = 0;

  vec_t V[10];
  initial begin
    V[0] = '{1'b0, 8'h80, 28'h8000018, 2'b00, 1'b0, 32'h40000002, 1'b0}; // tie, odd -> up
    V[1] = '{1'b0, 8'h7F, 28'hFFFFFF9, 2'b00, 1'b0, 32'h40000000, 1'b0}; // carry renorm
    V[2] = '{1'b1, 8'hFE, 28'hFFFFFFC, 2'b00, 1'b0, 32'hFF800000, 1'b1}; // overflow
    V[3] = '{1'b0, 8'h80, 28'h8000008, 2'b10, 1'b1, 32'h40000000, 1'b0}; // sub tie, no up
    V[4] = '{1'b0, 8'h80, 28'h8000008, 2'b10, 1'b0, 32'h40000001, 1'b0}; // add sticky, up
    V[5] = '{1'b0, 8'hFF, 28'h8400018, 2'b00, 1'b0, 32'h7F840001, 1'b0}; // inf/NaN bypass
    V[6] = '{1'b0, 8'h00, 28'h0000019, 2'b00, 1'b0, 32'h00000001, 1'b0}; // denorm, up
    V[7] = '{1'b0, 8'h00, 28'hFFFFFF8, 2'b00, 1'b0, 32'h00800000, 1'b0}; // denorm -> normal
    V[8] = '{1'b1, 8'h81, 28'h8123450, 2'b00, 1'b0, 32'hC0812345, 1'b0}; // exact, sign
    V[9] = '{1'b0, 8'h80, 28'h8000008, 2'b11, 1'b1, 32'h40000001, 1'b0}; // sub sticky, up
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input int idx, input vec_t v, input logic vld);
    if (idx == 0) begin
      s0 = v.sign; e0 = v.exp; m0 = v.mant; l0 = v.loss; op0 = v.op; v0 = vld;
    end else begin
      s1 = v.sign; e1 = v.exp; m1 = v.mant; l1 = v.loss; op1 = v.op; v1 = vld;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input int idx, input vec_t v);
    int  t = 0;
    bit  done = 0;
    drive(idx, v, 1'b1);
    while (!done) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        sbq.push_back('{v.dat, idx[0], v.ovf});
        done = 1;
      end else begin
        stall_seen = 1;
        t++;
        if (t > 200) begin
          chk("send_timeout", 32'd1, 32'd0);
          done = 1;
        end
      end
      @(posedge clk); #1;
    end
    drive(idx, v, 1'b0);
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", sbq.size(), 0);
    chk("drain_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_output", out_data, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", out_data, e.dat);
        chk("out_tag", {31'd0, out_tag}, {31'd0, e.tag});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
        tag_log.push_back(out_tag);
      end
    end
    if (rst_n && req_valid == 2'b11)
      chk("one_grant", {30'd0, req_ready}, (req_ready == 2'b10) ? 32'd2 : 32'd1);
  end

  logic exp_tags [6];
  initial begin
    exp_tags = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    drive(0, V[8], 1'b1);
    drive(1, V[8], 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", {31'd0, out_tag}, 0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 0);
    chk("rst_rnd_cnt", {28'd0, rnd_cnt}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request: latency and round-up count
    send(0, V[0]);
    chk("lat_s1_only", {31'd0, out_valid}, 0);
    chk("busy_inflight", {31'd0, busy}, 1);
    @(posedge clk); #1;
    chk("lat_out_valid", {31'd0, out_valid}, 1);
    drain();
    chk("cnt_after_1", {28'd0, rnd_cnt}, 1);

    // Rounding cases, alternating requesters
    for (int i = 1; i <= 8; i++) send(i % 2, V[i]);
    drain();
    chk("cnt_after_vec", {28'd0, rnd_cnt}, 6);

    // Arbitration with both requesters continuously valid
    do_reset();
    tag_log.delete();
    fork
      begin send(0, V[0]); send(0, V[4]); send(0, V[8]); end
      begin send(1, V[1]); send(1, V[3]); send(1, V[6]); end
    join
    drain();
    chk("arb_count", tag_log.size(), 6);
    for (int i = 0; i < 6 && i < tag_log.size(); i++)
      chk("arb_tag_order", {31'd0, tag_log[i]}, {31'd0, exp_tags[i]});
    chk("cnt_after_arb", {28'd0, rnd_cnt}, 4);

    // Backpressure mid-stream
    stall_seen = 0;
    fork
      begin send(0, V[0]); send(0, V[1]); send(0, V[4]); send(0, V[9]); end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_ready_dropped", {31'd0, stall_seen}, 1);
    chk("cnt_after_bp", {28'd0, rnd_cnt}, 8);

    // Counter saturation
    for (int i = 0; i < 10; i++) send(i % 2, V[0]);
    drain();
    chk("cnt_saturate", {28'd0, rnd_cnt}, 15);

    // Reset with results in flight
    out_ready = 1'b0;
    send(0, V[0]);
    send(1, V[1]);
    chk("hold_out_valid", {31'd0, out_valid}, 1);
    drive(0, V[2], 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("amid_out_valid", {31'd0, out_valid}, 0);
    chk("amid_busy", {31'd0, busy}, 0);
    chk("amid_rnd_cnt", {28'd0, rnd_cnt}, 0);
    chk("amid_req_ready", {30'd0, req_ready}, 0);
    chk("amid_out_data", out_data, 0);
    sbq.delete();
    drive(0, V[2], 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {31'd0, out_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
